// File: rtl/life_pkg.sv
// life_pkg: shared board size, controller states and default generation rate
package life_pkg;
    localparam int GRID_W           = 64;
    localparam int TICK_DIV_DEFAULT = 12_500_000;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, STEP} gen_state_t;
endpackage

// File: rtl/edge_detect.sv
// edge_detect: one-cycle pulse on each rising edge of a level input
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);
    logic in_d;
    // remember last cycle's level so a held input yields a single pulse
    always_ff @(posedge clk or negedge reset)
        if (!reset) in_d <= 1'b0;
        else        in_d <= in;
    assign rise = in & ~in_d;
endmodule

// File: rtl/life_gen_ctrl.sv
// life_gen_ctrl: owns the Life grid and decides when to load, step or free-run it
module life_gen_ctrl
    import life_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GRID_W-1:0] seed,
    input  logic              load,
    input  logic              run,
    input  logic              step,
    input  logic [GRID_W-1:0] next_grid,
    output logic [GRID_W-1:0] grid,
    output logic [CNT_W-1:0]  gen_count,
    output logic              running,
    output logic              stable
);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    gen_state_t    state;
    logic [TW-1:0] tick;
    logic          step_rise;
    logic          changed;

    edge_detect u_step_edge (
        .clk   (clk),
        .reset (reset),
        .in    (step),
        .rise  (step_rise)
    );

    assign changed = next_grid != grid;

    // generation sequencer: load beats run beats step, and a pattern that
    // stops changing freezes the board until the next load
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state     <= IDLE;
            grid      <= '0;
            gen_count <= '0;
            running   <= 1'b0;
            stable    <= 1'b0;
            tick      <= '0;
        end else begin
            case (state)
                IDLE:
                    if (load) state <= LOAD;
                    else if (!stable && run) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (!stable && step_rise) state <= STEP;
                LOAD: begin
                    grid      <= seed;
                    gen_count <= '0;
                    stable    <= 1'b0;
                    tick      <= '0;
                    state     <= IDLE;
                end
                RUN:
                    if (load) begin
                        state   <= LOAD;
                        running <= 1'b0;
                    end else if (!run) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        tick    <= '0;
                    end else if (tick == TICK_LAST) begin
                        tick <= '0;
                        if (changed) begin
                            grid      <= next_grid;
                            gen_count <= gen_count + CNT_W'(1);
                        end else begin
                            stable  <= 1'b1;
                            state   <= IDLE;
                            running <= 1'b0;
                        end
                    end else tick <= tick + TW'(1);
                STEP:
                    if (load) state <= LOAD;
                    else begin
                        state <= IDLE;
                        if (changed) begin
                            grid      <= next_grid;
                            gen_count <= gen_count + CNT_W'(1);
                        end else stable <= 1'b1;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_life_gen_ctrl.sv
// tb_life_gen_ctrl: random and directed checks of the generation controller against a behavioural model
module tb_life_gen_ctrl;
    localparam int TD = 4;
    localparam logic [63:0] BLINKER  = 64'h0000_0000_0007_0000;
    localparam logic [63:0] BLINKER2 = 64'h0000_0000_0202_0200;
    localparam logic [63:0] BLOCK    = 64'h0000_0000_1818_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] seed = '0;
    logic        load = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [63:0] next_grid;
    logic [63:0] grid;
    logic [15:0] gen_count;
    logic        running;
    logic        stable;

    int n_checks = 0;
    int n_fail = 0;

    life_gen_ctrl #(.TICK_DIV(TD), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .seed      (seed),
        .load      (load),
        .run       (run),
        .step      (step),
        .next_grid (next_grid),
        .grid      (grid),
        .gen_count (gen_count),
        .running   (running),
        .stable    (stable)
    );

    always #5 clk = ~clk;

    // Conway's rule on an 8x8 board with dead borders
    function automatic logic [63:0] life(input logic [63:0] g);
        logic [63:0] r;
        int n;
        r = '0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if ((dy != 0 || dx != 0) && y + dy >= 0 && y + dy < 8 && x + dx >= 0 && x + dx < 8)
                            n += int'(g[8 * (y + dy) + (x + dx)]);
                r[8 * y + x] = (n == 3) || (g[8 * y + x] && n == 2);
            end
        return r;
    endfunction

    always_comb next_grid = life(grid);

    // behavioural model: pending load/step one-shots, a run flag and the
    // number of cycles spent running decide when a generation is taken
    logic [63:0] m_grid = '0;
    logic [15:0] m_cnt = '0;
    logic        m_stable = 1'b0;
    logic        m_run = 1'b0;
    logic        m_pload = 1'b0;
    logic        m_pstep = 1'b0;
    logic        m_prev = 1'b0;
    int          m_age = 0;

    task automatic m_advance();
        logic [63:0] nx;
        nx = life(m_grid);
        if (nx != m_grid) begin
            m_grid = nx;
            m_cnt = m_cnt + 16'd1;
        end else begin
            m_stable = 1'b1;
            m_run = 1'b0;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        logic rise;
        if (!reset) begin
            m_grid = '0; m_cnt = '0; m_stable = 0; m_run = 0;
            m_pload = 0; m_pstep = 0; m_prev = 0; m_age = 0;
        end else begin
            rise = step && !m_prev;
            m_prev = step;
            if (m_pload) begin
                m_grid = seed; m_cnt = '0; m_stable = 0; m_pload = 0;
            end else if (m_pstep) begin
                m_pstep = 0;
                if (load) m_pload = 1;
                else m_advance();
            end else if (m_run) begin
                if (load) begin m_run = 0; m_pload = 1; end
                else if (!run) m_run = 0;
                else begin
                    m_age++;
                    if (m_age % TD == 0) m_advance();
                end
            end else if (load) m_pload = 1;
            else if (!m_stable && run) begin m_run = 1; m_age = 0; end
            else if (!m_stable && rise) m_pstep = 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("grid", grid, m_grid);
            check("gen_count", 64'(gen_count), 64'(m_cnt));
            check("running", 64'(running), 64'(m_run));
            check("stable", 64'(stable), 64'(m_stable));
        end
    endtask

    task automatic do_load(input logic [63:0] s);
        seed = s; load = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(2);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            seed = {$urandom, $urandom}; load = 1'($urandom); run = 1'($urandom); step = 1'($urandom);
            cyc(1);
        end
        check("rst_grid", grid, 64'd0);
        check("rst_running", 64'(running), 64'd0);
        seed = '0; load = 0; run = 0; step = 0; reset = 1'b1;
        cyc(20);
        check("idle_grid", grid, 64'd0);
        check("idle_count", 64'(gen_count), 64'd0);

        do_load(BLINKER);
        check("load_grid", grid, BLINKER);
        step = 1'b1; cyc(10); step = 1'b0; cyc(3);
        check("step1_grid", grid, BLINKER2);
        check("step1_count", 64'(gen_count), 64'd1);
        step = 1'b1; cyc(2); step = 1'b0; cyc(3);
        check("step2_grid", grid, BLINKER);
        check("step2_count", 64'(gen_count), 64'd2);

        do_load(BLINKER);
        run = 1'b1; cyc(6);
        step = 1'b1; cyc(2); step = 1'b0; cyc(5);
        check("run_count", 64'(gen_count), 64'd3);
        check("run_grid", grid, BLINKER2);
        check("run_running", 64'(running), 64'd1);
        run = 1'b0; cyc(6);
        check("stop_running", 64'(running), 64'd0);
        check("stop_count", 64'(gen_count), 64'd3);

        do_load(BLOCK);
        run = 1'b1; cyc(6);
        check("stable_flag", 64'(stable), 64'd1);
        check("stable_running", 64'(running), 64'd0);
        check("stable_count", 64'(gen_count), 64'd0);
        step = 1'b1; cyc(2); step = 1'b0; cyc(4);
        check("stable_hold", 64'(running), 64'd0);
        run = 1'b0;
        do_load(BLINKER);
        check("stable_clear", 64'(stable), 64'd0);

        run = 1'b1; cyc(4);
        load = 1'b1; cyc(1); load = 1'b0;
        check("coll_grid", grid, BLINKER);
        check("coll_count", 64'(gen_count), 64'd0);
        cyc(12);

        #2 reset = 1'b0;
        #1;
        check("async_grid", grid, 64'd0);
        check("async_running", 64'(running), 64'd0);
        check("async_count", 64'(gen_count), 64'd0);
        cyc(1);
        reset = 1'b1; cyc(10);

        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 2))
                0: seed = BLINKER;
                1: seed = BLOCK;
                default: seed = {$urandom, $urandom};
            endcase
            load = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) run = ~run;
            step = ($urandom_range(0, 3) == 0);
            cyc(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/life_gen_ctrl.md
# life_gen_ctrl

Generation controller for the 8x8 Life board. It owns the 64-bit current-grid register and sequences the combinational next-generation datapath, which computes `next_grid` from `grid`. It loads the seed pattern, advances one generation per step-button press or at a fixed tick rate while the run switch is on, and stops automatically when the pattern becomes stable. It sits between the board switches/buttons and the LED-matrix driver, which displays `grid`.

## Interface
- `GRID_W`, 64, board cells (8x8, bit 8*row+col)
- `TICK_DIV`, 12_500_000, clock cycles per generation in run mode (≥2; bench uses 4)
- `CNT_W`, 16, generation counter width
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  one clock; reset is asynchronous and active-low
- `seed`  in  GRID_W  initial pattern, sampled on load
- `load`  in  1  level; load seed, highest priority
- `run`  in  1  level switch; free-run at tick rate
- `step`  in  1  button; one generation per rising edge
- `next_grid`  in  GRID_W  datapath result for current `grid`
- `grid`  out  GRID_W  current generation (registered)
- `gen_count`  out  CNT_W  generations since last load
- `running`  out  1  high while state = RUN
- `stable`  out  1  sticky; `next_grid` equalled `grid` at an advance point

## Operation
- Reset values: `grid`=0, `gen_count`=0, `running`=0, `stable`=0, state IDLE, tick counter 0, step history 0.
- The state register is enumerated as IDLE, LOAD, RUN, STEP.
- Priority in every state is load, then run, then step.
- IDLE:
  - load → LOAD.
  - Otherwise, if stable=0: run → RUN.
  - Otherwise, if stable=0: step rising edge → STEP.
  - When stable=1, run and step are ignored.
- LOAD (1 cycle): `grid`←`seed`, `gen_count`←0, `stable`←0, tick←0. Next state is IDLE.
- RUN:
  - load → LOAD.
  - run=0 → IDLE, tick←0.
  - Otherwise tick increments. When tick = TICK_DIV-1, an advance occurs and tick←0.
- STEP (1 cycle): advance. Next state is IDLE, or LOAD if load=1.
- Advance:
  - If `next_grid`≠`grid`: `grid`←`next_grid`, `gen_count`←`gen_count`+1. The counter wraps all-ones→0.
  - If equal: grid and count unchanged, `stable`←1. From RUN the next state is IDLE.
- Step edge detect: `step` & ~step_d, where step_d is registered every cycle. A held button produces exactly one edge.
- Step edges arriving while in RUN are ignored; they are not queued.
- An all-zero grid is stable by definition, since the datapath returns 0.

## Timing
- Load: load sampled high at edge E gives state LOAD. At E+1, `grid`=`seed` and `gen_count`=0.
- Step: rising edge sampled at E gives state STEP. `grid` and `gen_count` update at E+1. The next step edge is accepted at E+2 or later.
- Run:
  - run sampled high at E gives state RUN, with `running`=1 after E.
  - First advance at E+TICK_DIV, then every TICK_DIV cycles.
  - run sampled low at edge F gives `running`=0 after F. No advance occurs at F.
- `running` is a Moore output (state==RUN). `grid`, `gen_count` and `stable` are registers; there is no combinational path from inputs to outputs.
- load asserted in the same cycle as an advance point: load wins. The advance is discarded.
- Reset asserted mid-run: all outputs go to their reset values immediately (async). Operation resumes from IDLE on the first edge after release.
- `next_grid` must be valid combinationally in the cycle an advance is taken. There is no handshake; the datapath is zero-latency.

## Structure
- `life_pkg` holds:
  - `GRID_W`
  - `typedef enum logic [1:0] {IDLE, LOAD, RUN, STEP} gen_state_t`
  - the default `TICK_DIV`
- Sub-module `edge_detect` (clk, reset, in, rise) is instantiated for `step`. It is reused by the board-level button logic.
- The tick counter is sized `$clog2(TICK_DIV)`.
- The Life-rule datapath stays outside this block.

## Test plan
- Reset: hold reset=0 with random inputs → `grid`=0, `gen_count`=0, `running`=0, `stable`=0. After release with inputs idle, everything stays unchanged for 20 cycles.
- Load: seed=64'h0000_0000_0007_0000 (blinker), pulse load 1 cycle → `grid`=seed, `gen_count`=0 one edge later. A preceding `stable`=1 is cleared.
- Step:
  - Reference model drives next_grid (blinker ↔ 64'h0000_0000_0202_0200).
  - Hold step high 10 cycles → exactly one advance, `gen_count`=1.
  - Second press → grid back to seed, `gen_count`=2.
- Run, TICK_DIV=4:
  - run=1 for 13 cycles → advances at entry+4, +8, +12, `gen_count`=3, `running`=1 throughout.
  - run=0 → `running`=0 and no further change.
  - Step pressed during run → no extra advance.
- Stable: seed 64'h0000_0000_1818_0000 (block), model returns same grid, run=1 → at the first tick `stable`=1, state IDLE, `gen_count`=0. Step and run are ignored until load.
- Collisions and mid-run reset:
  - load asserted on an advance-point cycle → `grid`=seed, `gen_count`=0. With run still high, RUN resumes and the next advance comes TICK_DIV cycles later.
  - reset pulsed mid-run → immediate reset values.
